// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter and sequencer sharing one spi_top master between NUM_REQ
// requesters; runs one tx/rx/full-duplex transfer at a time and returns status.
module spi_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SPI_TRF_BIT    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [2*NUM_REQ-1:0]           req_mode,
    input  logic [NUM_REQ*SPI_TRF_BIT-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [SPI_TRF_BIT-1:0]         rsp_rdata,
    output logic                           rsp_err,
    output logic                           busy,
    output logic [1:0]                     spi_req,
    output logic [SPI_TRF_BIT-1:0]         spi_din,
    input  logic [SPI_TRF_BIT-1:0]         spi_dout,
    input  logic                           spi_done_tx,
    input  logic                           spi_done_rx
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] REQ_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       id_r;
    logic [1:0]             mode_r;
    logic [SPI_TRF_BIT-1:0] rdata_r;
    logic                   tx_seen_r;
    logic                   rx_seen_r;
    logic [TO_W-1:0]        tcnt_r;
    logic [GAP_W-1:0]       gcnt_r;

    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [1:0]             win_mode_s;
    logic [SPI_TRF_BIT-1:0] win_wdata_s;
    logic                   tx_done_s;
    logic                   rx_done_s;
    logic                   xfer_done_s;
    logic                   timeout_s;

    // Two-pass cyclic search: indices at/after rr_ptr first, then wrap to the lowest valid
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_mode_s  = 2'd0;
        win_wdata_s = '0;
        for (int j = 0; j < 2 * NUM_REQ; j++) begin
            if (!win_found_s && req_valid[j % NUM_REQ] &&
                ((j >= NUM_REQ) || (IDX_W'(j) >= rr_ptr_r))) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(j % NUM_REQ);
                win_mode_s  = req_mode[2*(j % NUM_REQ) +: 2];
                win_wdata_s = req_wdata[(j % NUM_REQ)*SPI_TRF_BIT +: SPI_TRF_BIT];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Accept strobe is combinational so the grant lands in the request cycle
    always_comb begin
        req_ready = '0;
        if (rst && (state_r == S_IDLE) && win_found_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign tx_done_s = tx_seen_r | spi_done_tx;
    assign rx_done_s = rx_seen_r | spi_done_rx;
    assign timeout_s = (tcnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Completion condition per transfer mode
    always_comb begin
        case (mode_r)
            2'd1:    xfer_done_s = tx_done_s;
            2'd2:    xfer_done_s = rx_done_s;
            2'd3:    xfer_done_s = tx_done_s & rx_done_s;
            default: xfer_done_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            rr_ptr_r  <= '0;
            id_r      <= '0;
            mode_r    <= 2'd0;
            rdata_r   <= '0;
            tx_seen_r <= 1'b0;
            rx_seen_r <= 1'b0;
            tcnt_r    <= '0;
            gcnt_r    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            spi_req   <= 2'd0;
            spi_din   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (win_found_s) begin
                        id_r     <= win_idx_s;
                        mode_r   <= win_mode_s;
                        rr_ptr_r <= (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + 1'b1;
                        busy     <= 1'b1;
                        if (win_mode_s == 2'd0) begin
                            state_r   <= S_RESP;
                            rsp_valid <= REQ_LSB << win_idx_s;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state_r   <= S_XFER;
                            spi_req   <= win_mode_s;
                            spi_din   <= win_wdata_s;
                            tx_seen_r <= 1'b0;
                            rx_seen_r <= 1'b0;
                            tcnt_r    <= '0;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (spi_done_tx) begin
                        tx_seen_r <= 1'b1;
                    end
                    if (spi_done_rx) begin
                        rx_seen_r <= 1'b1;
                        rdata_r   <= spi_dout;
                    end
                    // A done arriving on the final timeout cycle still counts as success
                    if (xfer_done_s) begin
                        state_r   <= S_RESP;
                        rsp_valid <= REQ_LSB << id_r;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= (mode_r == 2'd1) ? '0 : (spi_done_rx ? spi_dout : rdata_r);
                        spi_req   <= 2'd0;
                    end else if (timeout_s) begin
                        state_r   <= S_RESP;
                        rsp_valid <= REQ_LSB << id_r;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        spi_req   <= 2'd0;
                    end else begin
                        tcnt_r <= tcnt_r + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    gcnt_r    <= '0;
                    state_r   <= S_GAP;
                end
                S_GAP: begin
                    if (gcnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gcnt_r <= gcnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    spi_req <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed self-checking bench for spi_xfer_arbiter; the spi_top side is a
// bench-driven stub so done ordering and missing dones can be forced.
module tb_spi_xfer_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 4;
    localparam int TO  = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_mode;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_rdata;
    logic           rsp_err;
    logic           busy;
    logic [1:0]     spi_req;
    logic [W-1:0]   spi_din;
    logic [W-1:0]   spi_dout;
    logic           spi_done_tx;
    logic           spi_done_rx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    spi_xfer_arbiter #(
        .NUM_REQ(N), .SPI_TRF_BIT(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .spi_req(spi_req), .spi_din(spi_din),
        .spi_dout(spi_dout), .spi_done_tx(spi_done_tx), .spi_done_rx(spi_done_rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // All checks and drives happen 1ns after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] mode, input logic [7:0] wdata);
        req_valid = req_valid | (4'b0001 << idx);
        req_mode  = (req_mode & ~(8'h03 << (2 * idx))) | ({6'b0, mode} << (2 * idx));
        req_wdata = (req_wdata & ~(32'h0000_00FF << (8 * idx))) | ({24'b0, wdata} << (8 * idx));
    endtask

    task automatic clr_req(input int idx);
        req_valid = req_valid & ~(4'b0001 << idx);
    endtask

    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == 4'b0000 && n < 64);
        ok = (req_ready != 4'b0000);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 4'b0000; req_mode = 8'h00; req_wdata = 32'h0;
        spi_dout = 8'h00; spi_done_tx = 1'b0; spi_done_rx = 1'b0;
        repeat (3) tick();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (spi_req !== 2'd0) begin errors++; $display("FAIL rst_spi_req: got %0d want 0", spi_req); end
        checks++; if (spi_din !== 8'h00) begin errors++; $display("FAIL rst_spi_din: got %h want 00", spi_din); end
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_tx();
        int n;
        spi_dout = 8'hFF;
        set_req(0, 2'd1, 8'hA5);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL tx_ready: got %b want 0001", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL tx_ready_once: got %b want 0000", req_ready); end
        clr_req(0);
        checks++; if (spi_req !== 2'd1) begin errors++; $display("FAIL tx_spi_req: got %0d want 1", spi_req); end
        checks++; if (spi_din !== 8'hA5) begin errors++; $display("FAIL tx_spi_din: got %h want a5", spi_din); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tx_busy: got %b want 1", busy); end
        tick(); tick();
        checks++; if (spi_req !== 2'd1 || spi_din !== 8'hA5 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL tx_hold: req %0d din %h rsp %b want 1 a5 0000", spi_req, spi_din, rsp_valid);
        end
        spi_done_tx = 1'b1;
        tick();
        spi_done_tx = 1'b0;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL tx_rsp_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL tx_rsp_err: got %b want 0", rsp_err); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL tx_rsp_rdata: got %h want 00", rsp_rdata); end
        checks++; if (spi_req !== 2'd0) begin errors++; $display("FAIL tx_req_drop: got %0d want 0", spi_req); end
        tick();
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1 || spi_req !== 2'd0) begin
            errors++; $display("FAIL tx_gap_entry: rsp %b busy %b req %0d want 0000 1 0", rsp_valid, busy, spi_req);
        end
        wait_idle(n);
        checks++; if (n != GAP) begin errors++; $display("FAIL gap_len: got %0d want %0d", n, GAP); end
        spi_dout = 8'h00;
    endtask

    task automatic test_single_rx();
        int n;
        set_req(2, 2'd2, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rx_ready: got %b want 0100", req_ready); end
        tick();
        clr_req(2);
        checks++; if (spi_req !== 2'd2) begin errors++; $display("FAIL rx_spi_req: got %0d want 2", spi_req); end
        tick();
        spi_dout = 8'h3C; spi_done_rx = 1'b1;
        tick();
        spi_dout = 8'h00; spi_done_rx = 1'b0;
        checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rx_rsp: valid %b rdata %h err %b want 0100 3c 0", rsp_valid, rsp_rdata, rsp_err);
        end
        wait_idle(n);
    endtask

    task automatic test_full_duplex();
        int n;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 2'd3, 8'h81);
            #1;
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fd%0d_ready: got %b want 0010", k, req_ready); end
            tick();
            clr_req(1);
            checks++; if (spi_req !== 2'd3 || spi_din !== 8'h81) begin
                errors++; $display("FAIL fd%0d_drive: req %0d din %h want 3 81", k, spi_req, spi_din);
            end
            if (k == 0) begin
                spi_done_tx = 1'b1; tick(); spi_done_tx = 1'b0;
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL fd0_early: got %b want 0000", rsp_valid); end
                spi_dout = 8'h7E; spi_done_rx = 1'b1; tick(); spi_done_rx = 1'b0; spi_dout = 8'h00;
            end else if (k == 1) begin
                spi_dout = 8'h7E; spi_done_rx = 1'b1; tick(); spi_done_rx = 1'b0; spi_dout = 8'h00;
                tick();
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL fd1_early: got %b want 0000", rsp_valid); end
                spi_done_tx = 1'b1; tick(); spi_done_tx = 1'b0;
            end else begin
                spi_dout = 8'h7E; spi_done_tx = 1'b1; spi_done_rx = 1'b1;
                tick();
                spi_done_tx = 1'b0; spi_done_rx = 1'b0; spi_dout = 8'h00;
            end
            checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h7E || rsp_err !== 1'b0) begin
                errors++; $display("FAIL fd%0d_rsp: valid %b rdata %h err %b want 0010 7e 0", k, rsp_valid, rsp_rdata, rsp_err);
            end
            tick();
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL fd%0d_single: got %b want 0000", k, rsp_valid); end
            wait_idle(n);
        end
        spi_dout = 8'h55; spi_done_tx = 1'b1; spi_done_rx = 1'b1;
        tick();
        spi_dout = 8'h00; spi_done_tx = 1'b0; spi_done_rx = 1'b0;
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL stray_done: busy %b rsp %b want 0 0000", busy, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        set_req(2, 2'd3, 8'h81);
        tick();
        clr_req(2);
        spi_done_tx = 1'b1; tick(); spi_done_tx = 1'b0;
        checks++; if (busy !== 1'b1 || spi_req !== 2'd3) begin
            errors++; $display("FAIL mid_pre: busy %b req %0d want 1 3", busy, spi_req);
        end
        set_req(0, 2'd2, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_rsp: valid %b rdata %h err %b want 0000 00 0", rsp_valid, rsp_rdata, rsp_err);
        end
        checks++; if (busy !== 1'b0 || spi_req !== 2'd0 || spi_din !== 8'h00 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_ctl: busy %b req %0d din %h ready %b want 0 0 00 0000", busy, spi_req, spi_din, req_ready);
        end
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL mid_rst_hold: got rsp/busy activity want none"); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_ready: got %b want 0001", req_ready); end
        tick();
        clr_req(0);
        checks++; if (spi_req !== 2'd2) begin errors++; $display("FAIL mid_after_req: got %0d want 2", spi_req); end
        spi_dout = 8'hC3; spi_done_rx = 1'b1; tick(); spi_done_rx = 1'b0; spi_dout = 8'h00;
        checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'hC3 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mid_after_rsp: valid %b rdata %h err %b want 0001 c3 0", rsp_valid, rsp_rdata, rsp_err);
        end
        wait_idle(n);
    endtask

    task automatic test_fairness();
        int       n;
        int       t_last;
        bit       ok;
        logic [3:0] exp_oh;
        int       exp_seq [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
        rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
        for (int i = 0; i < 4; i++) set_req(i, 2'd1, 8'(16 + i));
        #1;
        t_last = 0;
        for (int g = 0; g < 8; g++) begin
            if (req_ready == 4'b0000) wait_grant(ok); else ok = 1'b1;
            exp_oh = 4'b0001 << exp_seq[g];
            checks++; if (!ok || req_ready !== exp_oh) begin
                errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_oh);
            end
            if (g > 0) begin
                checks++; if (cyc - t_last != GAP + 3) begin
                    errors++; $display("FAIL b2b_period%0d: got %0d want %0d", g, cyc - t_last, GAP + 3);
                end
            end
            t_last = cyc;
            tick();
            checks++; if (spi_din !== 8'(16 + exp_seq[g])) begin
                errors++; $display("FAIL rr_din%0d: got %h want %h", g, spi_din, 8'(16 + exp_seq[g]));
            end
            spi_done_tx = 1'b1; tick(); spi_done_tx = 1'b0;
            checks++; if (rsp_valid !== exp_oh) begin
                errors++; $display("FAIL rr_rsp%0d: got %b want %b", g, rsp_valid, exp_oh);
            end
            if (g == 5) begin
                clr_req(0);
                clr_req(2);
            end
        end
        req_valid = 4'b0000;
        wait_idle(n);
    endtask

    task automatic test_errors();
        int n;
        bit early;
        set_req(3, 2'd0, 8'hEE);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL m0_ready: got %b want 1000", req_ready); end
        tick();
        clr_req(3);
        checks++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || spi_req !== 2'd0) begin
            errors++; $display("FAIL m0_rsp: valid %b err %b rdata %h req %0d want 1000 1 00 0", rsp_valid, rsp_err, rsp_rdata, spi_req);
        end
        tick();
        checks++; if (spi_req !== 2'd0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL m0_gap: req %0d rsp %b want 0 0000", spi_req, rsp_valid);
        end
        wait_idle(n);
        spi_dout = 8'h99;
        set_req(0, 2'd1, 8'h5A);
        tick();
        clr_req(0);
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            if (rsp_valid !== 4'b0000 || spi_req !== 2'd1) early = 1'b1;
            tick();
        end
        if (rsp_valid !== 4'b0000 || spi_req !== 2'd1) early = 1'b1;
        checks++; if (early) begin errors++; $display("FAIL to_hold: response or drop before %0d cycles", TO); end
        tick();
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || spi_req !== 2'd0) begin
            errors++; $display("FAIL to_rsp: valid %b err %b rdata %h req %0d want 0001 1 00 0", rsp_valid, rsp_err, rsp_rdata, spi_req);
        end
        spi_dout = 8'h00;
        wait_idle(n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_single_rx();
        test_full_duplex();
        test_reset_mid();
        test_fairness();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin arbiter and sequencer that shares a single `spi_top` master/slave pair between `NUM_REQ` independent requesters. It accepts one transfer at a time: transmit, receive, or full duplex. It drives the `spi_top` `req`/`din_master` controls and waits for `done_tx`/`done_rx`. It then returns the received word, with a status flag, to the granted requester. It sits between the system-side clients and `spi_top`, and is the only block allowed to drive `spi_top` request inputs.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SPI_TRF_BIT`, 8: transfer word width; must match `spi_top`.
- `GAP_CYCLES`, 4: idle `clk` cycles with `spi_req`=0 between transfers (≥1).
- `TIMEOUT_CYCLES`, 4096: maximum `clk` cycles in XFER before abort.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester transfer request.
- `req_mode`  in  2*NUM_REQ  per-requester mode, slice i = [2i+1:2i]: 1=tx, 2=rx, 3=full duplex, 0=illegal.
- `req_wdata`  in  NUM_REQ*SPI_TRF_BIT  per-requester tx word, slice i.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `rsp_valid`  out  NUM_REQ  one-hot completion strobe, one cycle.
- `rsp_rdata`  out  SPI_TRF_BIT  received word, valid with `rsp_valid`.
- `rsp_err`  out  1  error flag, valid with `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `spi_req`  out  2  to `spi_top` `req`.
- `spi_din`  out  SPI_TRF_BIT  to `spi_top` `din_master`.
- `spi_dout`  in  SPI_TRF_BIT  from `spi_top` `dout_master`.
- `spi_done_tx`  in  1  from `spi_top` `done_tx`.
- `spi_done_rx`  in  1  from `spi_top` `done_rx`.

## Operation
- FSM states: IDLE, XFER, RESP, GAP.
- IDLE: when any `req_valid` is high, the winner is the first valid index at or after `rr_ptr`, searching cyclically. `req_ready[winner]`=1 combinationally in the same cycle. On that edge the block captures `id`, `mode`, and `wdata`, and sets `rr_ptr`=winner+1 mod NUM_REQ.
- IDLE transition for legal mode: go to XFER and clear the done flags (`tx_seen`, `rx_seen`) and the timeout counter.
- IDLE transition for mode 0: go directly to RESP with `rsp_err`=1 and `rsp_rdata`=0. No SPI activity occurs.
- XFER: `spi_req`=mode and `spi_din`=captured wdata, both held constant for the whole state.
  - `spi_done_tx` sets `tx_seen`.
  - `spi_done_rx` sets `rx_seen` and captures `spi_dout` into the rdata register.
- XFER completion condition:
  - mode 1: `tx_seen` or `done_tx` this cycle.
  - mode 2: `rx_seen` or `done_rx` this cycle.
  - mode 3: both, in either order or in the same cycle.
- XFER exits: on completion go to RESP with `rsp_err`=0. If the timeout counter reaches TIMEOUT_CYCLES−1 first, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- For mode 1, `rsp_rdata`=0.
- RESP: `rsp_valid[id]`=1 for exactly one cycle, with `rsp_rdata`/`rsp_err` driven from registers. Then go to GAP.
- GAP: `spi_req`=0 for GAP_CYCLES cycles, using a counter of width $clog2(GAP_CYCLES+1). Then go to IDLE.
- Done pulses arriving outside XFER are ignored.
- Requesters must hold `req_valid`/`req_mode`/`req_wdata` stable until `req_ready`. Deasserting `req_valid` before grant withdraws the request.
- A requester must not re-request until its own `rsp_valid`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `spi_req`=0, `spi_din`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-transfer forces all of the above immediately (asynchronous). No response is issued for the aborted transfer.
- Grant latency: `req_ready` appears in the first IDLE cycle in which `req_valid` is high, i.e. the same cycle as the request.
- `spi_req` goes nonzero on the cycle after the handshake edge.
- `rsp_valid` appears exactly one cycle after the completing done pulse.
- `spi_req` returns to 0 in RESP, so a transfer deasserts `spi_req` ≥ GAP_CYCLES+1 cycles before the next one starts.
- Back-to-back throughput: one transfer per (transfer time + GAP_CYCLES + 2) cycles.
- All outputs are registered except `req_ready`.

## Test plan
- Single tx: requester 0, mode 1, wdata 0xA5. Required: `req_ready[0]` for one cycle; `spi_req`=1 and `spi_din`=0xA5 until `done_tx`; `rsp_valid[0]` one cycle later with `rsp_err`=0 and `rsp_rdata`=0; slave `dout_slave`=0xA5.
- Single rx: requester 2, mode 2, slave `din_slave`=0x3C. Required: `rsp_valid[2]` with `rsp_rdata`=0x3C and `rsp_err`=0.
- Full duplex with done ordering: mode 3, wdata 0x81, slave 0x7E. Repeat three times with `done_tx` before, after, and in the same cycle as `done_rx` (forced by a stub). Required in every case: a single `rsp_valid` with `rsp_rdata`=0x7E.
- Fairness: all four requesters held valid continuously. Required grant order 0,1,2,3,0,1. Then only requesters 1 and 3 valid with `rr_ptr`=2. Required order 3,1.
- Errors: mode 0 gives `rsp_err`=1 within 2 cycles and `spi_req` stays 0. A stubbed `spi_top` that never signals done, with TIMEOUT_CYCLES=64, gives `rsp_err`=1 exactly 64 cycles after XFER entry and then `spi_req`=0.
- Reset mid-XFER: `rst` low for 3 cycles during a mode 3 transfer. Required: all outputs at reset values immediately and no `rsp_valid` for the aborted transfer. A subsequent request completes normally.
